// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store initiator between the CPU datapath and the data memory.
// Takes one request at a time (valid/ready), drives the memory port, and returns
// load data or an out-of-range error through a valid/ready response channel.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   reqValid/reqReady        request handshake; reqWrite, reqAddr, reqData request fields
//   rspValid/rspReady        response handshake; rspData, rspErr response fields
//   addr, wrData             memory address / write data (held from accept to next accept)
//   memRead, memWrite        memory enables
//   rdData                   memory read data (only meaningful while memRead = 1)
module mem_access_ctrl #(
  parameter int unsigned ADDR_LIMIT  = 32768,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [15:0] reqAddr,
  input  logic [15:0] reqData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [15:0] rspData,
  output logic        rspErr,
  output logic [15:0] addr,
  output logic [15:0] wrData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [15:0] rdData
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          accept_c;
  logic          out_of_range_c;

  assign accept_c       = reqValid && req_ready_q;
  // One extra bit so ADDR_LIMIT = 65536 still compares correctly.
  assign out_of_range_c = (17'(reqAddr) >= 17'(ADDR_LIMIT));

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          addr_d    = reqAddr;
          wr_data_d = reqData;
          cnt_d     = '0;
          if (out_of_range_c) begin
            state_d    = RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else if (reqWrite) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        state_d    = RESP;
        rsp_err_d  = 1'b0;
        rsp_data_d = '0;
      end
      RD: begin
        // rdData is captured on the edge that ends the last memRead cycle.
        if (cnt_q == CW'(WAIT_CYCLES)) begin
          state_d    = RESP;
          rsp_err_d  = 1'b0;
          rsp_data_d = rdData;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rspReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    mem_read_d  = (state_d == RD);
    mem_write_d = (state_d == WR);
  end

  // State and output registers; reset clears memWrite immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_data_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign reqReady = req_ready_q;
  assign rspValid = rsp_valid_q;
  assign rspData  = rsp_data_q;
  assign rspErr   = rsp_err_q;
  assign addr     = addr_q;
  assign wrData   = wr_data_q;
  assign memRead  = mem_read_q;
  assign memWrite = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: table of directed requests plus hand-written
// sequences for wait states, response back-pressure, throughput and mid-write reset.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data, addr, wr_data, rd_data;
  logic        mem_read, mem_write;

  logic        req_valid3, req_ready3, req_write3;
  logic [15:0] req_addr3, req_data3;
  logic        rsp_valid3, rsp_ready3, rsp_err3;
  logic [15:0] rsp_data3, addr3, wr_data3, rd_data3;
  logic        mem_read3, mem_write3;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  mem_access_ctrl #(.ADDR_LIMIT(32768), .WAIT_CYCLES(0)) dut (
    .clk(clk), .rst(rst),
    .reqValid(req_valid), .reqReady(req_ready), .reqWrite(req_write),
    .reqAddr(req_addr), .reqData(req_data),
    .rspValid(rsp_valid), .rspReady(rsp_ready), .rspData(rsp_data), .rspErr(rsp_err),
    .addr(addr), .wrData(wr_data), .memRead(mem_read), .memWrite(mem_write),
    .rdData(rd_data)
  );

  mem_access_ctrl #(.ADDR_LIMIT(32768), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .reqValid(req_valid3), .reqReady(req_ready3), .reqWrite(req_write3),
    .reqAddr(req_addr3), .reqData(req_data3),
    .rspValid(rsp_valid3), .rspReady(rsp_ready3), .rspData(rsp_data3), .rspErr(rsp_err3),
    .addr(addr3), .wrData(wr_data3), .memRead(mem_read3), .memWrite(mem_write3),
    .rdData(rd_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 256 words indexed by addr[7:0]; bus floats when not read.
  assign rd_data  = mem_read  ? mem[addr[7:0]]  : 16'hzzzz;
  assign rd_data3 = mem_read3 ? mem[addr3[7:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (mem_write)  mem[addr[7:0]]  <= wr_data;
    if (mem_write3) mem[addr3[7:0]] <= wr_data3;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Enable invariants, checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst) begin
      chk("mem_enable_invariant",
          32'((mem_read && mem_write) || ((rsp_valid || req_ready) && (mem_read || mem_write))), 0);
      chk("mem_enable_invariant3",
          32'((mem_read3 && mem_write3) || ((rsp_valid3 || req_ready3) && (mem_read3 || mem_write3))), 0);
    end
  end

  // One full request/response on the WAIT_CYCLES=0 instance, rspReady held 1.
  task automatic do_req(input vec_t v, input int idx);
    int n;
    int lat;
    int rd_cnt;
    int wr_cnt;
    int addr_bad;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.a; req_data = v.d; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_timeout"}, 32'(req_ready), 1);
    @(posedge clk);
    #1;
    // Scramble request fields after accept; the controller must ignore them.
    req_valid = 1'b0; req_write = ~v.wr; req_addr = ~v.a; req_data = ~v.d;
    lat = 0; rd_cnt = 0; wr_cnt = 0; addr_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if ((mem_read || mem_write) && addr !== v.a) addr_bad++;
      if (mem_write && wr_data !== v.d) addr_bad++;
    end while (!rsp_valid && lat < 40);
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(v.exp_data));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    chk({tag, "_mem_read_cycles"}, 32'(rd_cnt), (!v.wr && !v.exp_err) ? 32'd1 : 32'd0);
    chk({tag, "_mem_write_cycles"}, 32'(wr_cnt), (v.wr && !v.exp_err) ? 32'd1 : 32'd0);
    chk({tag, "_addr_stable"}, 32'(addr_bad), 0);
    @(negedge clk);
    chk({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 0);
    chk({tag, "_ready_after"}, 32'(req_ready), 1);
  endtask

  initial begin
    int n;
    int lat;
    int rd_cnt;
    int acc;
    int wrs;
    int bad;

    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h02BC;

    //            wr    addr      data      exp_data  err  lat
    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 16'h02BC, 1'b0, 2};
    vecs[1] = '{1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 2};
    vecs[2] = '{1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 2};
    vecs[3] = '{1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[4] = '{1'b0, 16'h7FFF, 16'h0000, 16'h10FF, 1'b0, 2};
    vecs[5] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1};
    vecs[6] = '{1'b0, 16'h00FF, 16'h0000, 16'h10FF, 1'b0, 2};
    vecs[7] = '{1'b1, 16'h7FFF, 16'hABCD, 16'h0000, 1'b0, 2};
    vecs[8] = '{1'b0, 16'h00FF, 16'h0000, 16'hABCD, 1'b0, 2};

    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
    req_valid3 = 1'b0; req_write3 = 1'b0; req_addr3 = '0; req_data3 = '0; rsp_ready3 = 1'b0;

    #12;
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_err", 32'(rsp_err), 0);
    chk("reset_mem_en", 32'({mem_read, mem_write}), 0);
    chk("reset_addr", 32'(addr), 0);
    chk("reset_wr_data", 32'(wr_data), 0);
    chk("reset_rsp_data", 32'(rsp_data), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) do_req(vecs[i], i);

    // WAIT_CYCLES=3: memRead for 4 cycles, response in cycle 5 after accept.
    @(negedge clk);
    req_valid3 = 1'b1; req_write3 = 1'b0; req_addr3 = 16'h0010; rsp_ready3 = 1'b1;
    n = 0;
    while (!req_ready3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait3_ready_timeout", 32'(req_ready3), 1);
    @(posedge clk);
    #1;
    req_valid3 = 1'b0; req_addr3 = 16'hFFFF;
    lat = 0; rd_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_read3) rd_cnt++;
    end while (!rsp_valid3 && lat < 40);
    chk("wait3_latency", 32'(lat), 5);
    chk("wait3_mem_read_cycles", 32'(rd_cnt), 4);
    chk("wait3_rsp_data", 32'(rsp_data3), 32'h1234);
    chk("wait3_rsp_err", 32'(rsp_err3), 0);

    // Back-to-back stores with rspReady tied high: one accept every 3 cycles.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0030; req_data = 16'h7777; rsp_ready = 1'b1;
    acc = 0; wrs = 0;
    for (int c = 0; c < 9; c++) begin
      if (req_ready) acc++;
      if (mem_write) wrs++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 3);
    chk("b2b_writes", 32'(wrs), 3);
    chk("b2b_mem", 32'(mem[8'h30]), 32'h7777);

    // Response back-pressure: rspReady low for 10 cycles while a store is offered.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_write = 1'b1; req_data = 16'hDEAD;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_valid", 32'(rsp_valid), 1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_err !== 1'b0) bad++;
      if (req_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("stall_frozen", 32'(bad), 0);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 32'(rsp_valid), 0);
    do_req('{1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 2}, 9);

    // Reset asserted in the middle of the WR cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_data = 16'h5555; rsp_ready = 1'b1;
    n = 0;
    while (!mem_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("rstwr_in_wr", 32'(mem_write), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstwr_mem_write", 32'(mem_write), 0);
    chk("rstwr_outputs", 32'({req_ready, rsp_valid, rsp_err, mem_read}), 0);
    chk("rstwr_addr", 32'(addr), 0);
    chk("rstwr_wr_data", 32'(wr_data), 0);
    chk("rstwr_rsp_data", 32'(rsp_data), 0);
    @(negedge clk);
    rst = 1'b1;
    chk("rstwr_word_kept", 32'(mem[8'h20]), 32'h1020);
    do_req('{1'b0, 16'h0020, 16'h0000, 16'h1020, 1'b0, 2}, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
